// File: rtl/lift_pkg.sv
// Shared types and default sizing for the lift scan controller.
package lift_pkg;

  localparam int DEF_NUM_FLOORS  = 64;
  localparam int DEF_FLOOR_W     = 7;
  localparam int DEF_MOVE_CYCLES = 4;
  localparam int DEF_DOOR_CYCLES = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR
  } state_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lift_req_scan.sv
// Combinational summary of the pending-request bitmap relative to the car position.
module lift_req_scan
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] requests,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic [FLOOR_W-1:0]    max_request,
  output logic [FLOOR_W-1:0]    min_request,
  output logic                  pending,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  at_floor
);

  // NOTE: every output gets a default before the loops so no path leaves one unassigned (no latches).
  always_comb begin
    max_request = '0;
    min_request = '0;
    any_above   = 1'b0;
    any_below   = 1'b0;
    at_floor    = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (requests[i]) begin
        max_request = FLOOR_W'(i);
        if (i > int'(current_floor)) any_above = 1'b1;
        if (i < int'(current_floor)) any_below = 1'b1;
        if (i == int'(current_floor)) at_floor = 1'b1;
      end
    end
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (requests[i]) min_request = FLOOR_W'(i);
    end
  end

  assign pending = |requests;

endmodule

// File: rtl/lift_scan_ctrl.sv
// Single-car SCAN (elevator) controller: latches floor requests, sweeps in one
// direction serving them, reverses when nothing remains ahead.
module lift_scan_ctrl
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int FLOOR_W     = DEF_FLOOR_W,
  parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] requests,
  output logic [FLOOR_W-1:0]    max_request,
  output logic [FLOOR_W-1:0]    min_request,
  output logic                  pending,
  output logic                  up,
  output logic                  down,
  output logic                  door_open,
  output logic                  stop
);

  localparam int CNT_W = $clog2(imax(MOVE_CYCLES, DOOR_CYCLES)) + 1;
  localparam logic [CNT_W-1:0]      MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] BIT0      = NUM_FLOORS'(1);

  state_e                  state_q, state_d;
  dir_e                    dir_q, dir_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_FLOORS-1:0]   requests_q, requests_d;
  logic                    stop_q, stop_d;

  logic [NUM_FLOORS-1:0]   set_mask, clr_mask;
  logic [FLOOR_W-1:0]      floor_up, floor_dn;
  logic                    hit_up, hit_dn;
  logic                    any_above, any_below, at_floor;
  logic                    door_rereq;

  lift_req_scan #(
    .NUM_FLOORS(NUM_FLOORS),
    .FLOOR_W   (FLOOR_W)
  ) u_scan (
    .requests     (requests_q),
    .current_floor(floor_q),
    .max_request  (max_request),
    .min_request  (min_request),
    .pending      (pending),
    .any_above    (any_above),
    .any_below    (any_below),
    .at_floor     (at_floor)
  );

  assign floor_up = floor_q + FLOOR_W'(1);
  assign floor_dn = floor_q - FLOOR_W'(1);

  always_comb begin
    hit_up = 1'b0;
    hit_dn = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i == int'(floor_up)) hit_up = requests_q[i];
      if (i == int'(floor_dn)) hit_dn = requests_q[i];
    end
  end

  // A hall call for the floor whose door is already open just holds the door.
  assign door_rereq = req_valid && (state_q == S_DOOR) && (req_floor == floor_q);

  always_comb begin
    set_mask = '0;
    if (req_valid && (int'(req_floor) < NUM_FLOORS) && !door_rereq) set_mask = BIT0 << req_floor;
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    floor_d  = floor_q;
    cnt_d    = cnt_q;
    stop_d   = 1'b0;
    clr_mask = '0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (at_floor) begin
          state_d  = S_DOOR;
          clr_mask = BIT0 << floor_q;
        end else if (any_above && (dir_q == DIR_UP || !any_below)) begin
          state_d = S_MOVE_UP;
          dir_d   = DIR_UP;
        end else if (any_below) begin
          state_d = S_MOVE_DOWN;
          dir_d   = DIR_DOWN;
        end
      end
      S_MOVE_UP: begin
        if (cnt_q == MOVE_LAST) begin
          cnt_d = '0;
          // No target ahead means no step: this also keeps the car inside the shaft.
          if (!any_above) begin
            state_d = S_IDLE;
          end else begin
            floor_d = floor_up;
            if (hit_up) begin
              state_d  = S_DOOR;
              clr_mask = BIT0 << floor_up;
              stop_d   = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_MOVE_DOWN: begin
        if (cnt_q == MOVE_LAST) begin
          cnt_d = '0;
          if (!any_below) begin
            state_d = S_IDLE;
          end else begin
            floor_d = floor_dn;
            if (hit_dn) begin
              state_d  = S_DOOR;
              clr_mask = BIT0 << floor_dn;
              stop_d   = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DOOR: begin
        if (door_rereq) begin
          cnt_d = '0;
        end else if (cnt_q == DOOR_LAST) begin
          cnt_d = '0;
          if (dir_q == DIR_UP) begin
            if (any_above) state_d = S_MOVE_UP;
            else if (any_below) begin
              state_d = S_MOVE_DOWN;
              dir_d   = DIR_DOWN;
            end else state_d = S_IDLE;
          end else begin
            if (any_below) state_d = S_MOVE_DOWN;
            else if (any_above) begin
              state_d = S_MOVE_UP;
              dir_d   = DIR_UP;
            end else state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear is applied after set so an arrival beats a same-cycle re-request.
  assign requests_d = (requests_q | set_mask) & ~clr_mask;

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dir_q      <= DIR_UP;
      floor_q    <= '0;
      cnt_q      <= '0;
      requests_q <= '0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      floor_q    <= floor_d;
      cnt_q      <= cnt_d;
      requests_q <= requests_d;
      stop_q     <= stop_d;
    end
  end

  assign current_floor = floor_q;
  assign requests      = requests_q;
  assign up            = (state_q == S_MOVE_UP);
  assign down          = (state_q == S_MOVE_DOWN);
  assign door_open     = (state_q == S_DOOR);
  assign stop          = stop_q;

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Scenario bench for lift_scan_ctrl with a queue of expected stop floors.
module tb_lift_scan_ctrl;

  localparam int NUM_FLOORS = 64;
  localparam int FLOOR_W    = 7;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic [FLOOR_W-1:0]    req_floor;
  logic [FLOOR_W-1:0]    current_floor;
  logic [NUM_FLOORS-1:0] requests;
  logic [FLOOR_W-1:0]    max_request, min_request;
  logic                  pending, up, down, door_open, stop;

  int errors = 0;
  int checks = 0;
  int exp_stops[$];

  always #5 clk = ~clk;

  lift_scan_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .current_floor(current_floor),
    .requests     (requests),
    .max_request  (max_request),
    .min_request  (min_request),
    .pending      (pending),
    .up           (up),
    .down         (down),
    .door_open    (door_open),
    .stop         (stop)
  );

  function automatic logic [FLOOR_W-1:0] ref_max(input logic [NUM_FLOORS-1:0] r);
    logic [FLOOR_W-1:0] m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) if (r[i]) m = FLOOR_W'(i);
    return m;
  endfunction

  function automatic logic [FLOOR_W-1:0] ref_min(input logic [NUM_FLOORS-1:0] r);
    logic [FLOOR_W-1:0] m = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) if (r[i]) m = FLOOR_W'(i);
    return m;
  endfunction

  // Scoreboard: every stop pulse must match the next expected floor with the door open.
  always @(negedge clk) begin
    int f;
    if (reset === 1'b0) begin
      checks++;
      if (up === 1'b1 && down === 1'b1) begin
        errors++;
        $display("FAIL up_down_exclusive: up=%b down=%b, required not both", up, down);
      end
      if (stop === 1'b1) begin
        checks++;
        if (exp_stops.size() == 0) begin
          errors++;
          $display("FAIL stop_unexpected: stop at floor %0d, none expected", current_floor);
        end else begin
          f = exp_stops.pop_front();
          if (current_floor !== FLOOR_W'(f) || door_open !== 1'b1) begin
            errors++;
            $display("FAIL stop_floor: floor=%0d door=%b, required floor=%0d door=1",
                     current_floor, door_open, f);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int floor);
    req_valid = 1'b1;
    req_floor = FLOOR_W'(floor);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_scan_outputs(input string tag);
    checks++;
    if (max_request !== ref_max(requests) || min_request !== ref_min(requests) ||
        pending !== (|requests)) begin
      errors++;
      $display("FAIL %s_maxmin: max=%0d min=%0d pend=%b, required max=%0d min=%0d pend=%b",
               tag, max_request, min_request, pending, ref_max(requests), ref_min(requests),
               |requests);
    end
  endtask

  task automatic wait_floor(input int floor, input int budget, input string tag);
    int n = 0;
    while (current_floor !== FLOOR_W'(floor) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: floor=%0d, required %0d within %0d cycles", tag, current_floor,
               floor, budget);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(exp_stops.size() == 0 && up === 1'b0 && down === 1'b0 && door_open === 1'b0) &&
           n < budget) begin
      tick();
      check_scan_outputs(tag);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_idle_timeout: %0d stops outstanding after %0d cycles", tag,
               exp_stops.size(), budget);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b1;
    req_floor = FLOOR_W'(5);
    tick();
    tick();
    reset     = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (current_floor !== '0 || requests !== '0 || {up, down, door_open, stop, pending} !== 5'b0 ||
        max_request !== '0 || min_request !== '0) begin
      errors++;
      $display("FAIL reset_state: floor=%0d req=%h flags=%b max=%0d min=%0d, required all zero",
               current_floor, requests, {up, down, door_open, stop, pending}, max_request,
               min_request);
    end
  endtask

  task automatic test_single_trip();
    exp_stops.push_back(3);
    request(3);
    checks++;
    if (requests !== 64'h8 || up !== 1'b0) begin
      errors++;
      $display("FAIL trip_latch: req=%h up=%b, required req=8 up=0", requests, up);
    end
    tick();
    checks++;
    if (up !== 1'b1) begin
      errors++;
      $display("FAIL trip_up_rise: up=%b, required 1", up);
    end
    for (int k = 1; k < 12; k++) begin
      tick();
      checks++;
      if (up !== 1'b1 || door_open !== 1'b0) begin
        errors++;
        $display("FAIL trip_travel: cycle %0d up=%b door=%b, required up=1 door=0", k, up,
                 door_open);
      end
    end
    tick();
    checks++;
    if (current_floor !== 7'd3 || stop !== 1'b1 || door_open !== 1'b1 || requests !== '0) begin
      errors++;
      $display("FAIL trip_arrive: floor=%0d stop=%b door=%b req=%h, required 3/1/1/0",
               current_floor, stop, door_open, requests);
    end
    for (int k = 1; k < 3; k++) begin
      tick();
      checks++;
      if (door_open !== 1'b1 || stop !== 1'b0) begin
        errors++;
        $display("FAIL trip_dwell: cycle %0d door=%b stop=%b, required door=1 stop=0", k,
                 door_open, stop);
      end
    end
    tick();
    checks++;
    if ({up, down, door_open} !== 3'b000 || requests !== '0) begin
      errors++;
      $display("FAIL trip_idle: flags=%b req=%h, required idle, no requests",
               {up, down, door_open}, requests);
    end
  endtask

  task automatic test_out_of_range();
    request(64);
    request(127);
    tick();
    checks++;
    if (requests !== '0 || {up, down, door_open} !== 3'b000 || current_floor !== 7'd3) begin
      errors++;
      $display("FAIL range_ignore: req=%h flags=%b floor=%0d, required no change at floor 3",
               requests, {up, down, door_open}, current_floor);
    end
  endtask

  task automatic test_scan_sweep();
    do_reset();
    request(20);
    wait_floor(5, 100, "sweep_reach5");
    request(10);
    request(2);
    checks++;
    if (requests !== ((64'd1 << 20) | (64'd1 << 10) | (64'd1 << 2)) || up !== 1'b1) begin
      errors++;
      $display("FAIL sweep_bitmap: req=%h up=%b, required 100404 up=1", requests, up);
    end
    check_scan_outputs("sweep_bitmap");
    exp_stops.push_back(10);
    exp_stops.push_back(20);
    exp_stops.push_back(2);
    wait_idle(600, "sweep");
    checks++;
    if (current_floor !== 7'd2 || requests !== '0) begin
      errors++;
      $display("FAIL sweep_end: floor=%0d req=%h, required floor 2 no requests", current_floor,
               requests);
    end
  endtask

  task automatic test_door_rerequest();
    int n = 0;
    exp_stops.push_back(5);
    request(5);
    while (door_open !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100 || current_floor !== 7'd5) begin
      errors++;
      $display("FAIL rereq_arrive: floor=%0d door=%b, required door open at 5", current_floor,
               door_open);
    end
    tick();
    request(5);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (door_open !== 1'b1 || requests[5] !== 1'b0) begin
        errors++;
        $display("FAIL rereq_hold: cycle %0d door=%b req5=%b, required door=1 req5=0", k,
                 door_open, requests[5]);
      end
      tick();
    end
    checks++;
    if (door_open !== 1'b0 || requests !== '0) begin
      errors++;
      $display("FAIL rereq_close: door=%b req=%h, required door=0 no requests", door_open,
               requests);
    end
  endtask

  task automatic test_back_to_back();
    exp_stops.push_back(10);
    request(10);
    tick();
    checks++;
    if (up !== 1'b1) begin
      errors++;
      $display("FAIL b2b_up: up=%b, required 1", up);
    end
    repeat (19) tick();
    checks++;
    if (current_floor !== 7'd9 || up !== 1'b1) begin
      errors++;
      $display("FAIL b2b_approach: floor=%0d up=%b, required floor 9 up=1", current_floor, up);
    end
    request(10);
    checks++;
    if (current_floor !== 7'd10 || stop !== 1'b1 || requests !== '0) begin
      errors++;
      $display("FAIL b2b_arrive: floor=%0d stop=%b req=%h, required 10/1/0", current_floor, stop,
               requests);
    end
    tick();
    checks++;
    if (stop !== 1'b0 || requests !== '0) begin
      errors++;
      $display("FAIL b2b_single_pulse: stop=%b req=%h, required stop=0 req=0", stop, requests);
    end
    wait_idle(50, "b2b");
  endtask

  task automatic test_reset_mid_move();
    request(0);
    wait_floor(7, 100, "midreset_reach7");
    checks++;
    if (down !== 1'b1) begin
      errors++;
      $display("FAIL midreset_moving: down=%b, required 1", down);
    end
    reset     = 1'b1;
    req_valid = 1'b1;
    req_floor = FLOOR_W'(12);
    tick();
    checks++;
    if (current_floor !== '0 || requests !== '0 || {up, down, door_open, stop} !== 4'b0) begin
      errors++;
      $display("FAIL midreset_state: floor=%0d req=%h flags=%b, required all zero", current_floor,
               requests, {up, down, door_open, stop});
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (requests !== '0 || {up, down, door_open} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_after: req=%h flags=%b, required idle no requests", requests,
               {up, down, door_open});
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_floor = '0;
    test_reset();
    test_single_trip();
    test_out_of_range();
    test_scan_sweep();
    test_door_rerequest();
    test_back_to_back();
    test_reset_mid_move();
    checks++;
    if (exp_stops.size() != 0) begin
      errors++;
      $display("FAIL stops_outstanding: %0d left, required 0", exp_stops.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lift_scan_ctrl.md
LIFT_SCAN_CTRL -- requirements
Module: lift_scan_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 64, number of served floors (2..127).
REQ-002 Parameter FLOOR_W, default 7, floor-index width; SHALL satisfy 2**FLOOR_W >= NUM_FLOORS.
REQ-003 Parameter MOVE_CYCLES, default 4, clock cycles to travel one floor (>=1).
REQ-004 Parameter DOOR_CYCLES, default 3, clock cycles the door stays open per stop (>=1).
REQ-005 clk  input  1  sole clock, all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  qualifies req_floor for one cycle.
REQ-008 req_floor  input  FLOOR_W  requested floor index.
REQ-009 current_floor  output  FLOOR_W  floor the car is at or last passed.
REQ-010 requests  output  NUM_FLOORS  pending-request bitmap, bit i = floor i.
REQ-011 max_request / min_request  output  FLOOR_W each  highest / lowest set bit of requests.
REQ-012 pending  output  1  OR of requests.
REQ-013 up / down  output  1 each  car moving up / down; never both high.
REQ-014 door_open  output  1  high throughout DOOR state.
REQ-015 stop  output  1  one-cycle pulse on the cycle the car arrives at a requested floor.

Function
REQ-016 States SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR; a dir register (UP/DOWN) records the last travel direction.
REQ-017 req_valid with req_floor < NUM_FLOORS SHALL set requests[req_floor] on the next edge; req_floor >= NUM_FLOORS SHALL be ignored.
REQ-018 A request for current_floor while in DOOR SHALL restart the dwell counter and SHALL NOT be latched.
REQ-019 A request for current_floor while in MOVE_* SHALL be latched and served after a later reversal.
REQ-020 IDLE: if requests[current_floor] set -> DOOR and clear it; else if any request above and (dir=UP or none below) -> MOVE_UP; else if any below -> MOVE_DOWN; else stay.
REQ-021 MOVE_*: count MOVE_CYCLES cycles; on expiry current_floor steps by +/-1; if the new floor is requested -> DOOR, clear bit, pulse stop in the same cycle.
REQ-022 MOVE_UP SHALL never step past NUM_FLOORS-1; MOVE_DOWN SHALL never step below 0.
REQ-023 DOOR: after DOOR_CYCLES cycles -> continue in dir if requests remain beyond current_floor in dir; else reverse if requests on the other side; else IDLE.
REQ-024 Simultaneous set and clear of the same bit (request arrives on arrival cycle) SHALL resolve to clear.
REQ-025 max_request, min_request SHALL be combinational from requests and both 0 when requests is empty.
REQ-026 up = (state==MOVE_UP), down = (state==MOVE_DOWN), door_open = (state==DOOR), all registered-state decodes.

Reset
REQ-027 On reset: state IDLE, dir UP, current_floor 0, requests 0, counters 0, stop/up/down/door_open 0.
REQ-028 Reset asserted mid-move or mid-door SHALL discard all requests and return to floor 0 on the next edge; req_valid during reset SHALL be ignored.

Structure
REQ-029 Package lift_pkg SHALL hold the state enum, the dir enum and default parameter constants.
REQ-030 Sub-module lift_req_scan SHALL compute max_request, min_request, pending and any-above/any-below from requests and current_floor.
REQ-031 Counters SHALL be sized $clog2(max(MOVE_CYCLES,DOOR_CYCLES))+1 bits.

Verification (defaults)
REQ-032 Reset, req 3 at floor 0 -> up high next cycle; current_floor=3, stop pulse, door_open exactly 12 cycles after up rises; door_open for 3 cycles; then IDLE, requests=0.
REQ-033 At floor 0 request 20 then, while moving past floor 5, request 10 and 2 -> stops at 10 then 20, reverses, stops at 2; max/min track the bitmap each cycle.
REQ-034 req_floor=64 and 127 with req_valid -> requests unchanged, state stays IDLE.
REQ-035 At floor 5 in DOOR, req 5 at dwell cycle 2 -> door_open extends to 3 cycles after the re-request; requests[5] never set.
REQ-036 Arrival at 10 same cycle as req 10 -> bit clear after edge, single stop pulse; reset while moving at floor 7 -> current_floor=0, requests=0, up=0 next cycle.
